// File: rtl/inert_spi_resp.sv
// inert_spi_resp: SPI mode-0 inertial sensor stand-in with a small register map and a timed data-ready INT
// Ports: clk/rst_n    system clock, asynchronous active-low reset
//        SS_n/SCLK/MOSI  SPI inputs from the master, asynchronous to clk
//        MISO          SPI data out, 0 whenever no frame is being shifted
//        INT           data-ready interrupt, set by a pitch snapshot, cleared by reading PITCH_H
//        ptch_smpl     pitch source captured at each snapshot
//        int_en        INT1_CTRL[1] mirror
module inert_spi_resp #(
    parameter int         INT_PERIOD   = 2048,
    parameter logic [7:0] WHO_AM_I_VAL = 8'h6A
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    output logic        INT,
    input  logic [15:0] ptch_smpl,
    output logic        int_en
);
    localparam int TW = $clog2(INT_PERIOD);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, state_nxt;
    logic [2:0] ss_q, sclk_q;
    logic [1:0] mosi_q;
    logic [15:0] rx, tx, held;
    logic [4:0] bit_cnt;
    logic [7:0] int1_ctrl, ctrl2_g, rd_data;
    logic [TW-1:0] tmr;
    logic ss_fall, ss_rise, sclk_rise, sclk_fall;
    logic start, shifting, idle, commit, wr, clr, dis;
    logic req, wrap, pend, snap;
    // Stages [1:0] synchronize; stage [2] is the previous value for edge detection.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            ss_q   <= 3'b111;
            sclk_q <= '0;
            mosi_q <= '0;
        end else begin
            ss_q   <= {ss_q[1:0], SS_n};
            sclk_q <= {sclk_q[1:0], SCLK};
            mosi_q <= {mosi_q[0], MOSI};
        end
    assign ss_fall   = ss_q[2] & ~ss_q[1];
    assign ss_rise   = ~ss_q[2] & ss_q[1];
    assign sclk_rise = ~sclk_q[2] & sclk_q[1];
    assign sclk_fall = sclk_q[2] & ~sclk_q[1];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    always_comb
        state_nxt = (state == SHIFT) ? (ss_rise ? DONE : SHIFT) :
                    (state == IDLE && ss_fall) ? SHIFT : IDLE;
    always_comb begin
        idle     = (state == IDLE);
        start    = idle && ss_fall;
        shifting = (state == SHIFT);
        commit   = (state == DONE) && (bit_cnt == 5'd16);
        MISO     = shifting && tx[15];
    end
    // rx[6:0] holds the address only while the command byte has just completed.
    always_comb
        case (rx[6:0])
            7'h0D:   rd_data = int1_ctrl;
            7'h0F:   rd_data = WHO_AM_I_VAL;
            7'h11:   rd_data = ctrl2_g;
            7'h22:   rd_data = held[7:0];
            7'h23:   rd_data = held[15:8];
            default: rd_data = 8'h00;
        endcase
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rx      <= '0;
            tx      <= '0;
            bit_cnt <= '0;
        end else if (start) begin
            rx      <= '0;
            tx      <= '0;
            bit_cnt <= '0;
        end else if (shifting) begin
            if (sclk_rise) begin
                rx      <= {rx[14:0], mosi_q[1]};
                bit_cnt <= bit_cnt + 5'd1;
            end
            if (sclk_fall)
                tx <= (bit_cnt == 5'd8) ? {rd_data, 8'h00} : {tx[14:0], 1'b0};
        end
    assign wr  = commit && !rx[15];
    assign clr = commit && rx[15] && (rx[14:8] == 7'h23);
    assign dis = wr && (rx[14:8] == 7'h0D) && !rx[1];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            int1_ctrl <= '0;
            ctrl2_g   <= '0;
        end else if (wr) begin
            if (rx[14:8] == 7'h0D) int1_ctrl <= rx[7:0];
            if (rx[14:8] == 7'h11) ctrl2_g   <= rx[7:0];
        end
    assign int_en = int1_ctrl[1];
    // A wrap counts as pending in its own cycle so an idle responder snapshots exactly on the wrap.
    // Snapshots wait for IDLE so a frame never sees held move; repeated wraps collapse into req.
    assign wrap = int_en && (tmr == TW'(INT_PERIOD - 1));
    assign pend = req || wrap;
    assign snap = pend && idle;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            tmr  <= '0;
            req  <= 1'b0;
            held <= '0;
            INT  <= 1'b0;
        end else begin
            tmr <= (!int_en || wrap) ? '0 : tmr + 1'b1;
            req <= int_en && !dis && pend && !snap;
            if (snap) held <= ptch_smpl;
            INT <= snap || (INT && !clr);
        end
endmodule

// File: tb/tb_inert_spi_resp.sv
// tb_inert_spi_resp: directed/randomized SPI frames against a register-map and pitch-hold reference model
module tb_inert_spi_resp;
    localparam int P = 64;
    localparam int H = 5;
    logic clk = 1'b0, rst_n = 1'b0, SS_n = 1'b1, SCLK = 1'b0, MOSI = 1'b0;
    logic [15:0] ptch_smpl = '0;
    logic MISO, INT, int_en;
    int n_cmp = 0, n_err = 0;
    logic [7:0] mem [128];
    bit wmask [128];
    logic [15:0] held_m;

    always #5 clk = ~clk;

    inert_spi_resp #(.INT_PERIOD(P), .WHO_AM_I_VAL(8'h6A)) dut (
        .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
        .MISO(MISO), .INT(INT), .ptch_smpl(ptch_smpl), .int_en(int_en)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Shifts nbits of cmd MSB first; MISO is sampled as the master would, at each SCLK rise.
    // ptch_smpl switches to newp at bit chg_bit; keep_ss leaves SS_n low on return.
    task automatic spi(input logic [15:0] cmd, input int nbits, input int chg_bit,
                       input logic [15:0] newp, input bit keep_ss, output logic [15:0] rsp);
        rsp = '0;
        @(negedge clk);
        SS_n = 1'b0;
        clks(6);
        for (int i = 0; i < nbits; i++) begin
            MOSI = cmd[15-i];
            if (i == chg_bit) ptch_smpl = newp;
            clks(H);
            SCLK = 1'b1;
            rsp[15-i] = MISO;
            clks(H);
            SCLK = 1'b0;
        end
        clks(H);
        if (!keep_ss) SS_n = 1'b1;
    endtask

    task automatic rd(input logic [6:0] a, output logic [7:0] d);
        logic [15:0] r;
        spi({1'b1, a, 8'h00}, 16, -1, '0, 1'b0, r);
        clks(8);
        d = r[7:0];
    endtask

    task automatic wr(input logic [6:0] a, input logic [7:0] d);
        logic [15:0] r;
        spi({1'b0, a, d}, 16, -1, '0, 1'b0, r);
        clks(8);
        if (wmask[a]) mem[a] = d;
    endtask

    function automatic logic [7:0] exp_rd(input logic [6:0] a);
        return (a == 7'h22) ? held_m[7:0] : (a == 7'h23) ? held_m[15:8] : mem[a];
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] d, v;
        logic [6:0] a;
        logic [15:0] r, p_old, p_new;
        logic [6:0] addrs [6];
        int t;
        bit low;
        addrs = '{7'h11, 7'h0F, 7'h00, 7'h22, 7'h23, 7'h7F};
        for (int i = 0; i < 128; i++) begin
            mem[i] = 8'h00;
            wmask[i] = 1'b0;
        end
        mem[7'h0F] = 8'h6A;
        wmask[7'h0D] = 1'b1;
        wmask[7'h11] = 1'b1;
        held_m = '0;

        clks(4);
        chk("rst_miso", MISO, 0);
        chk("rst_int", INT, 0);
        chk("rst_int_en", int_en, 0);
        rst_n = 1'b1;
        clks(4);

        rd(7'h0F, d);
        chk("who_am_i", d, 8'h6A);
        chk("who_int", INT, 0);
        chk("miso_idle", MISO, 0);

        spi({1'b0, 7'h11, 8'hAA}, 10, -1, '0, 1'b0, r);
        clks(8);
        rd(7'h11, d);
        chk("abort_ctrl2", d, exp_rd(7'h11));

        for (int i = 0; i < 6; i++) begin
            a = addrs[$urandom_range(0, 5)];
            v = 8'($urandom);
            wr(a, v);
            rd(a, d);
            chk("map_rd", d, exp_rd(a));
        end

        ptch_smpl = 16'h1234;
        spi({1'b0, 7'h0D, 8'h02}, 16, -1, '0, 1'b0, r);
        mem[7'h0D] = 8'h02;
        t = 0;
        while (!INT && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("int_rise_time", (t >= 64 && t <= 72), 1);
        held_m = 16'h1234;
        clks(4);
        rd(7'h0D, d);
        chk("int1_ctrl_rd", d, exp_rd(7'h0D));
        chk("int_en_on", int_en, 1);
        rd(7'h22, d);
        chk("pitch_l", d, exp_rd(7'h22));
        spi({1'b1, 7'h23, 8'h00}, 16, -1, '0, 1'b0, r);
        chk("pitch_h", r[7:0], exp_rd(7'h23));
        low = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (!INT) low = 1'b1;
        end
        chk("int_clear_seen", low, 1);
        chk("int_reassert", INT, 1);

        for (int k = 0; k < 3; k++) begin
            p_old = (k == 0) ? 16'h1111 : 16'($urandom);
            p_new = (k == 0) ? 16'h2222 : ~p_old;
            ptch_smpl = p_old;
            clks(P + 8);
            held_m = p_old;
            spi({1'b1, 7'h22, 8'h00}, 16, 2, p_new, 1'b0, r);
            chk("defer_old", r[7:0], exp_rd(7'h22));
            clks(8);
            held_m = p_new;
            rd(7'h22, d);
            chk("defer_new", d, exp_rd(7'h22));
        end

        p_old = 16'($urandom);
        p_new = ~p_old;
        ptch_smpl = p_old;
        clks(P + 8);
        held_m = p_old;
        spi({1'b1, 7'h23, 8'h00}, 16, 2, p_new, 1'b0, r);
        chk("coin_rd", r[7:0], exp_rd(7'h23));
        clks(8);
        held_m = p_new;
        chk("coin_int", INT, 1);
        rd(7'h22, d);
        chk("coin_held_l", d, exp_rd(7'h22));
        rd(7'h23, d);
        chk("coin_held_h", d, exp_rd(7'h23));

        spi({1'b0, 7'h0D, 8'h00}, 16, 2, ~p_new, 1'b0, r);
        clks(8);
        mem[7'h0D] = 8'h00;
        chk("int_en_off", int_en, 0);
        clks(2 * P);
        chk("dis_int_hold", INT, 1);
        rd(7'h22, d);
        chk("dis_no_snap", d, exp_rd(7'h22));
        rd(7'h23, d);
        chk("dis_held_h", d, exp_rd(7'h23));
        chk("dis_int_clr", INT, 0);
        clks(2 * P);
        chk("dis_int_stay0", INT, 0);

        wr(7'h0D, 8'h02);
        t = 0;
        while (!INT && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("int_again", INT, 1);
        spi({1'b1, 7'h0F, 8'h00}, 7, -1, '0, 1'b1, r);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_miso", MISO, 0);
        chk("rst_mid_int", INT, 0);
        chk("rst_mid_int_en", int_en, 0);
        @(negedge clk);
        SS_n = 1'b1;
        clks(3);
        rst_n = 1'b1;
        clks(4);
        for (int i = 0; i < 128; i++)
            if (wmask[i]) mem[i] = 8'h00;
        held_m = '0;
        rd(7'h0F, d);
        chk("post_rst_who", d, 8'h6A);
        rd(7'h22, d);
        chk("post_rst_held", d, exp_rd(7'h22));
        rd(7'h11, d);
        chk("post_rst_ctrl2", d, exp_rd(7'h11));
        chk("post_rst_int", INT, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/inert_spi_resp.md
Name: inert_spi_resp

Overview:
Synthesizable SPI responder that emulates the inertial sensor on the far end of the inertial interface's SS_n/SCLK/MOSI/MISO/INT bus. It decodes 16-bit mode-0 frames, serves a small register map, latches pitch samples from a source input, and raises data-ready INT at a fixed rate once the interrupt is enabled. It is used as the sensor stand-in for full-chip simulation and for FPGA bring-up without the physical sensor.

Parameters:
INT_PERIOD, 2048, clk cycles between pitch sample snapshots while the interrupt is enabled (minimum 64).
WHO_AM_I_VAL, 8'h6A, value returned by the read-only ID register.

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
SS_n  input  1  slave select from master, active-low, asynchronous to clk
SCLK  input  1  SPI clock from master, idles low
MOSI  input  1  master-out data
MISO  output  1  slave-out data
INT  output  1  data-ready interrupt, active-high
ptch_smpl  input  16  pitch value presented for capture; sampled only at snapshot
int_en  output  1  mirror of INT1_CTRL[1], for debug visibility

Behaviour:
- Clock and reset: clk and rst_n as stated under Ports.
- Input synchronization:
  - SS_n, SCLK and MOSI each pass through a 2-flop synchronizer.
  - Edges are detected from a third stage.
  - Requirement: SCLK high and low phases are each at least 4 clk.
- Frame format, SPI mode 0, MSB first, 16 bits:
  - bit15: R/W, 1 = read.
  - bits14:8: address.
  - bits7:0: write data, don't-care on reads.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE -> SHIFT on synchronized SS_n fall. Clears rx shift register, tx shift register and bit count.
  - SHIFT, SCLK rise: shift MOSI into rx[0]; bit count +1.
  - SHIFT, SCLK fall at bit count 8: load tx[15:8] with register data for the address held in rx[6:0]. rx[7] is R/W. Loading happens for reads and writes.
  - SHIFT, any other SCLK fall: shift tx left, fill 0.
  - SHIFT -> DONE on SS_n rise.
  - DONE, one cycle: if bit count == 16, commit. Otherwise discard the frame with no side effects. Then -> IDLE.
- MISO:
  - Equals tx[15] while SS_n is low. It is therefore 0 during the command byte.
  - Driven 0 while SS_n is high; no tristate.
- Register map:
  - All registers reset to 0 unless stated.
  - Unmapped addresses read 8'h00; writes to them are ignored.
  - 0x0D INT1_CTRL: read/write. Bit1 enables INT generation.
  - 0x0F WHO_AM_I: read-only, returns WHO_AM_I_VAL.
  - 0x11 CTRL2_G: read/write, storage only.
  - 0x22 PITCH_L: read-only, held[7:0].
  - 0x23 PITCH_H: read-only, held[15:8].
- Commit (DONE with bit count 16):
  - Write: update the addressed read/write register.
  - Read of 0x23: clear INT.
- Sample timer:
  - Runs only while INT1_CTRL[1] = 1.
  - Reset to 0 whenever the enable is 0.
  - At count INT_PERIOD-1 it wraps to 0 and posts a snapshot request.
- Snapshot:
  - Executes in the first cycle in which the request is pending and the FSM is in IDLE. A request made mid-frame is deferred until the frame ends, so a frame never sees held change.
  - Action: held <= ptch_smpl; INT <= 1.
  - Multiple requests while deferred collapse into one.
- Simultaneous events:
  - Snapshot and INT-clear in the same cycle: INT = 1, set wins.
  - Snapshot while INT is already 1: held is overwritten and INT stays 1.
- Disabling the interrupt:
  - Writing INT1_CTRL[1] = 0 clears any pending request.
  - It does not clear INT; INT clears only via a 0x23 read.
- Reset mid-frame: all state returns to IDLE/0 immediately, MISO = 0, INT = 0, held = 0. The partial frame is lost.
- Reset values: MISO 0, INT 0, int_en 0.
- Latency: a committed write is visible to a read issued in the very next frame.

Test Plan:
- Reset, then read 0x0F (frame 16'h8F00) -> MISO returns 8'h6A in bits 7:0; INT stays 0.
- Write 0x0D = 8'h02, read 0x0D back -> 8'h02 and int_en = 1. With ptch_smpl = 16'h1234 and INT_PERIOD = 64: INT rises 64 clk after the enabling write commits; reads of 0x22 and 0x23 return 8'h34 and 8'h12; INT clears 1 clk after the 0x23 frame's SS_n rise.
- Aborted frame: SS_n high after 10 SCLK on write 0x11 = 8'hAA -> 0x11 still reads 8'h00.
- Snapshot due mid-frame: ptch_smpl changes 16'h1111 -> 16'h2222 during a 0x22 read -> the frame returns the old byte. The snapshot then occurs 1 clk after DONE; the next read returns 8'h22.
- Snapshot coincident with a 0x23 read commit -> INT remains 1 and held updates.
- Assert rst_n mid-frame after 7 SCLK -> MISO 0 and INT 0 immediately. A following clean read of 0x0F returns 8'h6A.
